// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin AR arbiter sharing one AXI read slave, grant held until RLAST
module axi_rd_arbiter #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int ID_WIDTH   = 4,
    localparam int GW        = $clog2(NUM_M)
) (
    input  logic                        axi_tb_ACLK,
    input  logic                        axi_tb_ARESET,
    input  logic [NUM_M-1:0]            m_arvalid,
    output logic [NUM_M-1:0]            m_arready,
    input  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr,
    input  logic [NUM_M*LEN_WIDTH-1:0]  m_arlen,
    input  logic [NUM_M*3-1:0]          m_arsize,
    input  logic [NUM_M*2-1:0]          m_arburst,
    input  logic [NUM_M*ID_WIDTH-1:0]   m_arid,
    output logic                        s_arvalid,
    input  logic                        s_arready,
    output logic [ADDR_WIDTH-1:0]       s_araddr,
    output logic [LEN_WIDTH-1:0]        s_arlen,
    output logic [2:0]                  s_arsize,
    output logic [1:0]                  s_arburst,
    output logic [ID_WIDTH-1:0]         s_arid,
    input  logic                        s_rvalid,
    output logic                        s_rready,
    input  logic                        s_rlast,
    output logic [NUM_M-1:0]            m_rvalid,
    input  logic [NUM_M-1:0]            m_rready,
    output logic [GW-1:0]               grant_idx,
    output logic                        busy,
    output logic                        rlast_err
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t               state;
    logic [GW-1:0]        last_grant;
    logic [GW-1:0]        nxt;
    logic                 found;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_q;
    logic                 in_addr;
    logic                 in_data;

    always_comb begin
        nxt = grant_idx;
        found = 1'b0;
        for (int i = 1; i <= NUM_M; i++) begin
            if (!found && m_arvalid[(int'(last_grant) + i) % NUM_M]) begin
                nxt = GW'((int'(last_grant) + i) % NUM_M);
                found = 1'b1;
            end
        end
    end

    assign in_addr   = state == ADDR;
    assign in_data   = state == DATA;
    assign busy      = state != IDLE;
    assign s_arvalid = in_addr & m_arvalid[grant_idx];
    assign s_araddr  = in_addr ? m_araddr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_arlen   = in_addr ? m_arlen[grant_idx*LEN_WIDTH +: LEN_WIDTH] : '0;
    assign s_arsize  = in_addr ? m_arsize[grant_idx*3 +: 3] : '0;
    assign s_arburst = in_addr ? m_arburst[grant_idx*2 +: 2] : '0;
    assign s_arid    = in_addr ? m_arid[grant_idx*ID_WIDTH +: ID_WIDTH] : '0;
    assign m_arready = (in_addr & s_arready) ? NUM_M'(1) << grant_idx : '0;
    assign m_rvalid  = (in_data & s_rvalid) ? NUM_M'(1) << grant_idx : '0;
    assign s_rready  = in_data & m_rready[grant_idx];

    always_ff @(posedge axi_tb_ACLK) begin
        if (axi_tb_ARESET) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= GW'(NUM_M - 1);
            beat_cnt   <= '0;
            len_q      <= '0;
            rlast_err  <= 1'b0;
        end else begin
            rlast_err <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    grant_idx <= nxt;
                    state     <= ADDR;
                end
                ADDR: if (s_arvalid && s_arready) begin
                    len_q    <= s_arlen;
                    beat_cnt <= '0;
                    state    <= DATA;
                end
                DATA: if (s_rvalid && s_rready) begin
                    beat_cnt  <= &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
                    // length check only flags; only RLAST ends the burst
                    rlast_err <= s_rlast ? beat_cnt != len_q : beat_cnt == len_q;
                    if (s_rlast) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed bench with a transaction-level model checked every cycle
module tb_axi_rd_arbiter;
    localparam int N = 2, AW = 16, LW = 8, IW = 4;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0] m_araddr;
    logic [N*LW-1:0] m_arlen;
    logic [N*3-1:0]  m_arsize;
    logic [N*2-1:0]  m_arburst;
    logic [N*IW-1:0] m_arid;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, busy, rlast_err;
    logic [AW-1:0] s_araddr;
    logic [LW-1:0] s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic [IW-1:0] s_arid;
    logic [0:0]    grant_idx;
    int vecs = 0, errs = 0, g;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.NUM_M(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ID_WIDTH(IW)) dut (
        .axi_tb_ACLK(clk), .axi_tb_ARESET(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rlast(s_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .grant_idx(grant_idx), .busy(busy), .rlast_err(rlast_err)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: owner (-1 = nobody), whether its address phase is done, beats seen, burst length
    int m_own = -1, m_gi = 0, m_last = N - 1, m_cnt = 0, m_len = 0;
    bit m_data = 1'b0, m_err = 1'b0;

    function automatic int rr(input int last, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_own <= -1; m_data <= 1'b0; m_gi <= 0; m_last <= N - 1;
            m_cnt <= 0; m_len <= 0; m_err <= 1'b0;
        end else begin
            m_err <= 1'b0;
            if (m_own < 0) begin
                if (rr(m_last, m_arvalid) >= 0) begin
                    m_own <= rr(m_last, m_arvalid);
                    m_gi  <= rr(m_last, m_arvalid);
                end
            end else if (!m_data) begin
                if (m_arvalid[m_own] && s_arready) begin
                    m_len <= int'(m_arlen[m_own*LW +: LW]);
                    m_cnt <= 0;
                    m_data <= 1'b1;
                end
            end else if (s_rvalid && m_rready[m_own]) begin
                m_err <= s_rlast != (m_cnt == m_len);
                m_cnt <= m_cnt < 255 ? m_cnt + 1 : 255;
                if (s_rlast) begin
                    m_last <= m_own; m_own <= -1; m_data <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit ad, dt;
        int o;
        logic [N-1:0] oh;
        if (chk_en) begin
            ad = m_own >= 0 && !m_data;
            dt = m_own >= 0 && m_data;
            o  = m_own < 0 ? 0 : m_own;
            oh = N'(1) << o;
            check("busy", 32'(busy), 32'(m_own >= 0));
            check("grant_idx", 32'(grant_idx), m_gi);
            check("s_arvalid", 32'(s_arvalid), 32'(ad && m_arvalid[o]));
            check("s_araddr", 32'(s_araddr), ad ? 32'(m_araddr[o*AW +: AW]) : 0);
            check("s_arlen", 32'(s_arlen), ad ? 32'(m_arlen[o*LW +: LW]) : 0);
            check("s_arsize", 32'(s_arsize), ad ? 32'(m_arsize[o*3 +: 3]) : 0);
            check("s_arburst", 32'(s_arburst), ad ? 32'(m_arburst[o*2 +: 2]) : 0);
            check("s_arid", 32'(s_arid), ad ? 32'(m_arid[o*IW +: IW]) : 0);
            check("m_arready", 32'(m_arready), (ad && s_arready) ? 32'(oh) : 0);
            check("m_rvalid", 32'(m_rvalid), (dt && s_rvalid) ? 32'(oh) : 0);
            check("s_rready", 32'(s_rready), 32'(dt && m_rready[o]));
            check("rlast_err", 32'(rlast_err), 32'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [LW-1:0] l);
        m_araddr[i*AW +: AW] = a;
        m_arlen[i*LW +: LW]  = l;
        m_arsize[i*3 +: 3]   = 3'(i + 2);
        m_arburst[i*2 +: 2]  = 2'b01;
        m_arid[i*IW +: IW]   = IW'(i + 5);
        m_arvalid[i]         = 1'b1;
    endtask

    task automatic serve(input int nb, input int last_at, input bit keep, output int gi);
        int t = 0;
        while (!s_arvalid && t < 20) begin
            tick();
            t++;
        end
        check("ar_wait", 32'(s_arvalid), 1);
        gi = int'(grant_idx);
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        if (!keep) m_arvalid[gi] = 1'b0;
        m_rready = '1;
        for (int b = 0; b < nb; b++) begin
            s_rvalid = 1'b1;
            s_rlast  = b == last_at;
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        int exp_g[4] = '{0, 1, 0, 1};
        bit keep_g[4] = '{1, 1, 0, 0};
        rst = 1'b1;
        m_arvalid = '0; m_rready = '0; m_araddr = '0; m_arlen = '0;
        m_arsize = '0; m_arburst = '0; m_arid = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_busy", 32'(busy), 0);
        check("rst_grant", 32'(grant_idx), 0);
        check("rst_arvalid", 32'(s_arvalid), 0);
        check("rst_rready", 32'(s_rready), 0);
        rst = 1'b0;
        // Contested requests alternate starting at master 0
        set_req(0, 16'h0010, 8'd0);
        set_req(1, 16'h0020, 8'd0);
        for (int i = 0; i < 4; i++) begin
            serve(1, 0, keep_g[i], g);
            check("rr_seq", g, exp_g[i]);
        end
        tick();
        // Lone master 1 burst of 4
        set_req(1, 16'h0100, 8'd3);
        tick();
        check("m1_arvalid", 32'(s_arvalid), 1);
        check("m1_araddr", 32'(s_araddr), 32'h0100);
        check("m1_grant", 32'(grant_idx), 1);
        serve(4, 3, 0, g);
        check("m1_busy_after", 32'(busy), 0);
        check("m1_err", 32'(rlast_err), 0);
        // Slave stalls AR for 5 cycles
        set_req(0, 16'h0200, 8'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_arvalid", 32'(s_arvalid), 1);
            check("stall_araddr", 32'(s_araddr), 32'h0200);
            check("stall_arready", 32'(m_arready), 0);
            tick();
        end
        serve(2, 1, 0, g);
        // Early RLAST on beat 1 of 4
        set_req(1, 16'h0400, 8'd3);
        serve(2, 1, 0, g);
        check("early_err", 32'(rlast_err), 1);
        check("early_idle", 32'(busy), 0);
        tick();
        check("early_err_clr", 32'(rlast_err), 0);
        // RLAST missing at beat 3, arrives on beat 4
        set_req(0, 16'h0500, 8'd3);
        serve(5, 4, 0, g);
        check("late_err", 32'(rlast_err), 1);
        tick();
        // Reset during beat 2 of 4
        set_req(1, 16'h0300, 8'd3);
        tick();
        s_arready = 1'b1;
        tick();
        s_arready = 1'b0;
        m_arvalid = '0;
        s_rvalid = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("mrst_busy", 32'(busy), 0);
        check("mrst_rvalid", 32'(m_rvalid), 0);
        check("mrst_rready", 32'(s_rready), 0);
        rst = 1'b0;
        s_rvalid = 1'b0;
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
